// File: rtl/demux8_deser.sv
// demux8_deser: serial-to-parallel receiver for an 8-to-1 mux link.
//
// Each accepted bit (din_valid=1) is written into slot position k of a
// collect register. frame_start marks slot 0. When the last slot fills,
// the word is published on q with a one-cycle q_valid pulse.
//
// Parameters:
//   N   slots per frame / width of q (power of 2, >= 2)
//   SW  slot counter width (log2 N)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous reset, active low
//   din          serial data bit
//   din_valid    din carries a real bit this cycle
//   frame_start  din is slot 0 of a new frame (with din_valid)
//   q            last complete frame, q[k] = bit from slot k
//   q_valid      one-cycle pulse when q updates
//   slot         slot index the next accepted bit is written to
//   busy         partial frame held (state != IDLE)
//   frame_abort  one-cycle pulse: partial frame dropped by frame_start
//   parity_err   one-cycle pulse with q_valid on parity mismatch
//
// Optional feature macro: DEMUX_PARITY_EN
//   When defined, each frame is followed by one even-parity bit
//   (XOR of the N data bits) and parity_err reports a mismatch.
//   When undefined, parity_err is tied to 0.

module demux8_deser #(
    parameter int N  = 8,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din,
    input  logic          din_valid,
    input  logic          frame_start,
    output logic [N-1:0]  q,
    output logic          q_valid,
    output logic [SW-1:0] slot,
    output logic          busy,
    output logic          frame_abort,
    output logic          parity_err
);

`ifdef DEMUX_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_PARITY  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1
    } state_t;
`endif

    state_t        r_state;
    logic [N-1:0]  r_shift;
    logic [N-1:0]  r_q;
    logic          r_q_valid;
    logic [SW-1:0] r_slot;
    logic          r_busy;
    logic          r_abort;
    logic          r_perr;

    logic [N-1:0]  w_asm;
    logic [N-1:0]  w_fresh;
    logic          w_last;

    // Collect register with the current bit dropped into its slot.
    always_comb begin
        w_asm         = r_shift;
        w_asm[r_slot] = din;
    end

    // Start of a new frame: everything but slot 0 cleared so
    // leftovers from an abandoned frame cannot reach q.
    assign w_fresh = {{(N-1){1'b0}}, din};
    assign w_last  = (r_slot == SW'(N - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_slot    <= '0;
            r_busy    <= 1'b0;
            r_abort   <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            r_q_valid <= 1'b0;
            r_abort   <= 1'b0;
            r_perr    <= 1'b0;
            if (din_valid) begin
                unique case (r_state)
                    S_IDLE: begin
                        // Bits without frame_start are dropped here.
                        if (frame_start) begin
                            r_shift <= w_fresh;
                            r_slot  <= SW'(1);
                            r_busy  <= 1'b1;
                            r_state <= S_COLLECT;
                        end
                    end
                    S_COLLECT: begin
                        if (frame_start) begin
                            r_abort <= 1'b1;
                            r_shift <= w_fresh;
                            r_slot  <= SW'(1);
                        end else if (w_last) begin
                            r_shift <= w_asm;
                            r_slot  <= '0;
`ifdef DEMUX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_q       <= w_asm;
                            r_q_valid <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= S_IDLE;
`endif
                        end else begin
                            r_shift <= w_asm;
                            r_slot  <= r_slot + SW'(1);
                        end
                    end
`ifdef DEMUX_PARITY_EN
                    S_PARITY: begin
                        if (frame_start) begin
                            r_abort <= 1'b1;
                            r_shift <= w_fresh;
                            r_slot  <= SW'(1);
                            r_state <= S_COLLECT;
                        end else begin
                            // Even parity: din must equal XOR of data.
                            r_q       <= r_shift;
                            r_q_valid <= 1'b1;
                            r_perr    <= din ^ (^r_shift);
                            r_busy    <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end
`endif
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_slot  <= '0;
                    end
                endcase
            end
        end
    end

    assign q           = r_q;
    assign q_valid     = r_q_valid;
    assign slot        = r_slot;
    assign busy        = r_busy;
    assign frame_abort = r_abort;

`ifdef DEMUX_PARITY_EN
    assign parity_err = r_perr;
`else
    assign parity_err = 1'b0;
    logic w_unused;
    assign w_unused = r_perr;
`endif

endmodule

// File: tb/tb_demux8_deser.sv
// tb_demux8_deser: directed scoreboard bench for demux8_deser.
// Stimulus pushes expected {parity_err, q}; a monitor pops on q_valid.

module tb_demux8_deser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic       din_valid;
    logic       frame_start;
    logic [7:0] q;
    logic       q_valid;
    logic [2:0] slot;
    logic       busy;
    logic       frame_abort;
    logic       parity_err;

    demux8_deser #(.N(8), .SW(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .q           (q),
        .q_valid     (q_valid),
        .slot        (slot),
        .busy        (busy),
        .frame_abort (frame_abort),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

`ifdef DEMUX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic [8:0] exp_q[$];
    int         vt[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    logic       prev_qv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // Monitor: compare every q_valid against the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (q_valid === 1'b1) begin
                vt.push_back(cyc);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: got q=%0h want none", q);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("sb_q", {24'd0, q}, {24'd0, e[7:0]});
                    chk("sb_perr", {31'd0, parity_err}, {31'd0, e[8]});
                end
                if (prev_qv === 1'b1)
                    chk("qv_pulse", 32'd1, 32'd0);
            end else if (parity_err !== 1'b0) begin
                chk("perr_no_qv", {31'd0, parity_err}, 32'd0);
            end
        end
        prev_qv <= q_valid;
    end

    task automatic put(input logic b, input logic fs);
        din         = b;
        din_valid   = 1'b1;
        frame_start = fs;
        @(posedge clk);
        #1;
        din_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        din_valid   = 1'b0;
        frame_start = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // gap: 0 = back-to-back, else gaps of 1..gap cycles between bits.
    task automatic send_word(input logic [7:0] w, input int gap,
                             input bit abort_first, input bit par_bad);
        logic [7:0] qh;
        for (int k = 0; k < 8; k++) begin
            if (k == 7 && !PAR)
                exp_q.push_back({1'b0, w});
            put(w[k], k == 0);
            chk(abort_first && k == 0 ? "abort" : "no_abort",
                {31'd0, frame_abort},
                {31'd0, (abort_first && k == 0)});
            chk("slot", {29'd0, slot}, 32'((k + 1) % 8));
            chk("busy", {31'd0, busy}, {31'd0, (k < 7) || PAR});
            if (gap > 0 && k < 7) begin
                qh = q;
                idle(1 + (k % gap));
                chk("gap_slot", {29'd0, slot}, 32'(k + 1));
                chk("gap_q", {24'd0, q}, {24'd0, qh});
                chk("gap_qv", {31'd0, q_valid}, 32'd0);
            end
        end
        if (PAR) begin
            exp_q.push_back({par_bad, w});
            put((^w) ^ par_bad, 1'b0);
            chk("par_busy", {31'd0, busy}, 32'd0);
        end
        chk("q_word", {24'd0, q}, {24'd0, w});
        chk("q_valid", {31'd0, q_valid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst_n       = 1'b0;
        din         = 1'b1;
        din_valid   = 1'b0;
        frame_start = 1'b1;

        // 1: reset with din_valid toggling
        for (int i = 0; i < 2; i++) begin
            din_valid = (i == 0);
            @(posedge clk);
            #1;
        end
        chk("rst_q", {24'd0, q}, 32'd0);
        chk("rst_qv", {31'd0, q_valid}, 32'd0);
        chk("rst_slot", {29'd0, slot}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // bits without frame_start in IDLE are dropped
        put(1'b1, 1'b0);
        put(1'b0, 1'b0);
        chk("idle_drop_busy", {31'd0, busy}, 32'd0);
        chk("idle_drop_slot", {29'd0, slot}, 32'd0);

        // frame_start without din_valid is ignored
        frame_start = 1'b1;
        idle(1);
        chk("fs_novalid_busy", {31'd0, busy}, 32'd0);

        // 2: 8'hA5 contiguous
        send_word(8'hA5, 0, 1'b0, 1'b0);
        idle(2);
        chk("hold_q", {24'd0, q}, 32'hA5);

        // 3: 8'h3C with 1-3 cycle gaps
        send_word(8'h3C, 3, 1'b0, 1'b0);
        idle(2);

        // 4: 5 bits of 8'h0F, then a fresh 8'hFF frame aborts it
        for (int k = 0; k < 5; k++)
            put(k < 4, k == 0);
        chk("part_slot", {29'd0, slot}, 32'd5);
        send_word(8'hFF, 0, 1'b1, 1'b0);
        idle(2);

        // 5: reset after 4 bits of a frame
        for (int k = 0; k < 4; k++)
            put(k[0], k == 0);
        rst_n = 1'b0;
        idle(1);
        chk("mid_rst_slot", {29'd0, slot}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_qv", {31'd0, q_valid}, 32'd0);
        chk("mid_rst_q", {24'd0, q}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // 6: back-to-back 8'h01 then 8'h80
        n0 = vt.size();
        send_word(8'h01, 0, 1'b0, PAR);
        send_word(8'h80, 0, 1'b0, 1'b0);
        idle(3);
        chk("b2b_count", 32'(vt.size() - n0), 32'd2);
        if (vt.size() - n0 == 2)
            chk("b2b_spacing", 32'(vt[n0 + 1] - vt[n0]),
                PAR ? 32'd9 : 32'd8);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
